// File: rtl/fpu_addsub_pipe.sv
// fpu_addsub_pipe: parametrised IEEE-754 binary add/subtract, two pipeline stages.
// Stage 1 unpacks, orders operands by magnitude, aligns and adds.
// Stage 2 normalises, rounds to nearest-even and selects special results.
//
// Handshake: an input transfer happens on in_valid & in_ready, and an output
// transfer happens on out_valid & out_ready. A stage advances when it is empty
// or when the stage after it advances, so in_ready depends only on register
// state and out_ready, never on in_valid. While out_valid is high and out_ready
// is low, out_y, out_tag and out_flags hold.
module fpu_addsub_pipe #(
    parameter int EW   = 8,
    parameter int MW   = 23,
    parameter int TAGW = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sub,
    input  logic [EW+MW:0]    in_a,
    input  logic [EW+MW:0]    in_b,
    input  logic [TAGW-1:0]   in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EW+MW:0]    out_y,
    output logic [TAGW-1:0]   out_tag,
    output logic [2:0]        out_flags
);
    localparam int FW  = 1 + EW + MW;
    localparam int SW  = MW + 4;                       // hidden + fraction + guard/round/sticky
    localparam int LZW = $clog2(SW + 1);
    localparam int XW  = ((EW + 1 > LZW) ? EW + 1 : LZW) + 1;
    localparam logic [EW-1:0] EMAX = '1;
    localparam logic [FW-1:0] QBIT = {{(EW + 1){1'b0}}, 1'b1, {(MW - 1){1'b0}}};
    localparam logic [FW-1:0] CNAN = {1'b1, {EW{1'b1}}, 1'b1, {(MW - 1){1'b0}}};

    function automatic logic [LZW-1:0] f_lzc(input logic [SW-1:0] v);
        logic found;
        f_lzc = LZW'(SW);
        found = 1'b0;
        for (int i = SW - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                f_lzc = LZW'(SW - 1 - i);
                found = 1'b1;
            end
        end
    endfunction

    // ---------------- pipeline control ----------------
    logic r_s1_valid, r_s2_valid;
    logic w_s2_adv, w_s1_adv;
    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    // ---------------- stage 1: unpack, align, add ----------------
    logic            w_sa, w_sb, w_swap, w_big_s, w_sml_s, w_eff_sub;
    logic [EW-1:0]   w_ea, w_eb, w_big_e, w_sml_e, w_big_ee, w_sml_ee;
    logic [MW-1:0]   w_ma, w_mb, w_big_m, w_sml_m;
    logic [XW-1:0]   w_diff, w_shamt;
    logic [SW-1:0]   w_big_sig, w_sml_sig, w_sml_al;
    logic [2*SW-1:0] w_sh_wide;
    logic [SW:0]     w_sum;
    logic            w_a_nan, w_b_nan, w_a_inf, w_b_inf;
    logic            w_spec, w_spec_inv;
    logic [FW-1:0]   w_spec_y;

    assign w_sa      = in_a[FW-1];
    assign w_sb      = in_b[FW-1] ^ in_sub;
    assign w_ea      = in_a[FW-2:MW];
    assign w_eb      = in_b[FW-2:MW];
    assign w_ma      = in_a[MW-1:0];
    assign w_mb      = in_b[MW-1:0];
    // Raw exponent:mantissa bits order the same way as magnitudes.
    assign w_swap    = in_b[FW-2:0] > in_a[FW-2:0];
    assign w_big_s   = w_swap ? w_sb : w_sa;
    assign w_sml_s   = w_swap ? w_sa : w_sb;
    assign w_big_e   = w_swap ? w_eb : w_ea;
    assign w_sml_e   = w_swap ? w_ea : w_eb;
    assign w_big_m   = w_swap ? w_mb : w_ma;
    assign w_sml_m   = w_swap ? w_ma : w_mb;
    assign w_big_ee  = (w_big_e == '0) ? EW'(1) : w_big_e;
    assign w_sml_ee  = (w_sml_e == '0) ? EW'(1) : w_sml_e;
    assign w_diff    = XW'(w_big_ee) - XW'(w_sml_ee);
    assign w_shamt   = (w_diff > XW'(SW)) ? XW'(SW) : w_diff;
    assign w_big_sig = {|w_big_e, w_big_m, 3'b000};
    assign w_sml_sig = {|w_sml_e, w_sml_m, 3'b000};
    // Bits shifted past the sticky position collapse into the sticky bit.
    assign w_sh_wide = {w_sml_sig, {SW{1'b0}}} >> w_shamt;
    assign w_sml_al  = {w_sh_wide[2*SW-1:SW+1], w_sh_wide[SW] | (|w_sh_wide[SW-1:0])};
    assign w_eff_sub = w_big_s ^ w_sml_s;
    assign w_sum     = w_eff_sub ? ({1'b0, w_big_sig} - {1'b0, w_sml_al})
                                 : ({1'b0, w_big_sig} + {1'b0, w_sml_al});
    assign w_a_nan   = (w_ea == EMAX) && (w_ma != '0);
    assign w_b_nan   = (w_eb == EMAX) && (w_mb != '0);
    assign w_a_inf   = (w_ea == EMAX) && (w_ma == '0);
    assign w_b_inf   = (w_eb == EMAX) && (w_mb == '0);

    // Special-case result in priority order: a NaN, b NaN, inf-inf, single/same infs.
    always_comb begin
        w_spec     = 1'b0;
        w_spec_inv = 1'b0;
        w_spec_y   = '0;
        if (w_a_nan) begin
            w_spec   = 1'b1;
            w_spec_y = in_a | QBIT;
        end else if (w_b_nan) begin
            w_spec   = 1'b1;
            w_spec_y = in_b | QBIT;
        end else if (w_a_inf && w_b_inf && (w_sa != w_sb)) begin
            w_spec     = 1'b1;
            w_spec_inv = 1'b1;
            w_spec_y   = CNAN;
        end else if (w_a_inf) begin
            w_spec   = 1'b1;
            w_spec_y = in_a;
        end else if (w_b_inf) begin
            w_spec   = 1'b1;
            w_spec_y = {w_sb, in_b[FW-2:0]};
        end
    end

    logic            r_s1_sign, r_s1_zsign, r_s1_spec, r_s1_spec_inv;
    logic [SW:0]     r_s1_sum;
    logic [EW-1:0]   r_s1_exp;
    logic [FW-1:0]   r_s1_spec_y;
    logic [TAGW-1:0] r_s1_tag;

    // Stage-1 occupancy; reset discards whatever is in flight.
    always_ff @(posedge clk) begin
        if (!rstn)         r_s1_valid <= 1'b0;
        else if (w_s1_adv) r_s1_valid <= in_valid;
    end

    // Stage-1 payload captured on each accepted operation.
    always_ff @(posedge clk) begin
        if (w_s1_adv && in_valid) begin
            r_s1_sum      <= w_sum;
            r_s1_exp      <= w_big_ee;
            r_s1_sign     <= w_big_s;
            r_s1_zsign    <= w_sa & w_sb;
            r_s1_spec     <= w_spec;
            r_s1_spec_inv <= w_spec_inv;
            r_s1_spec_y   <= w_spec_y;
            r_s1_tag      <= in_tag;
        end
    end

    // ---------------- stage 2: normalise, round, select ----------------
    logic            w_carry, w_g, w_r, w_s, w_rup, w_inex, w_ovf;
    logic [SW-1:0]   w_lo, w_norm;
    logic [LZW-1:0]  w_lz;
    logic [XW-1:0]   w_emsh, w_nsh, w_nexp, w_fexp;
    logic [MW:0]     w_man;
    logic [MW+1:0]   w_rnd;
    logic [MW-1:0]   w_frac;
    logic [FW-1:0]   w_y;
    logic [2:0]      w_flags;

    assign w_carry = r_s1_sum[SW];
    assign w_lo    = r_s1_sum[SW-1:0];
    assign w_lz    = f_lzc(w_lo);
    // Left shift stops once the exponent would fall below 1 (subnormal result).
    assign w_emsh  = XW'(r_s1_exp) - XW'(1);
    assign w_nsh   = (XW'(w_lz) < w_emsh) ? XW'(w_lz) : w_emsh;
    assign w_norm  = w_carry ? {r_s1_sum[SW:2], r_s1_sum[1] | r_s1_sum[0]} : (w_lo << w_nsh);
    assign w_nexp  = w_carry ? (XW'(r_s1_exp) + XW'(1)) : (XW'(r_s1_exp) - w_nsh);
    assign w_man   = w_norm[SW-1:3];
    assign w_g     = w_norm[2];
    assign w_r     = w_norm[1];
    assign w_s     = w_norm[0];
    assign w_rup   = w_g && (w_r || w_s || w_man[0]);
    assign w_inex  = w_g || w_r || w_s;
    assign w_rnd   = {1'b0, w_man} + {{(MW + 1){1'b0}}, w_rup};

    // Exponent/fraction after rounding; a missing hidden bit means subnormal (exp 0).
    always_comb begin
        w_fexp = '0;
        w_frac = w_rnd[MW-1:0];
        if (w_rnd[MW+1]) begin
            w_fexp = w_nexp + XW'(1);
            w_frac = w_rnd[MW:1];
        end else if (w_rnd[MW]) begin
            w_fexp = w_nexp;
        end
    end

    assign w_ovf = w_fexp >= XW'(EMAX);

    // Final result select: specials, exact zero, overflow, then the rounded value.
    always_comb begin
        w_y     = {r_s1_sign, w_fexp[EW-1:0], w_frac};
        w_flags = {2'b00, w_inex};
        if (r_s1_spec) begin
            w_y     = r_s1_spec_y;
            w_flags = {r_s1_spec_inv, 2'b00};
        end else if (r_s1_sum == '0) begin
            w_y     = {r_s1_zsign, {(FW - 1){1'b0}}};
            w_flags = 3'b000;
        end else if (w_ovf) begin
            w_y     = {r_s1_sign, EMAX, {MW{1'b0}}};
            w_flags = 3'b011;
        end
    end

    logic [FW-1:0]   r_s2_y;
    logic [TAGW-1:0] r_s2_tag;
    logic [2:0]      r_s2_flags;

    // Output stage: holds its contents while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_s2_valid <= 1'b0;
            r_s2_y     <= '0;
            r_s2_tag   <= '0;
            r_s2_flags <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_y     <= w_y;
                r_s2_tag   <= r_s1_tag;
                r_s2_flags <= w_flags;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_y     = r_s2_y;
    assign out_tag   = r_s2_tag;
    assign out_flags = r_s2_flags;
endmodule

// File: tb/tb_fpu_addsub_pipe.sv
// Bench for fpu_addsub_pipe: table of hand-computed vectors, an expected queue
// filled on input transfers and drained on output transfers, stall/reset scenarios.
module tb_fpu_addsub_pipe;
    localparam int EW = 8, MW = 23, TAGW = 5, FW = 32, NV = 24;
    localparam int W = TAGW + 3 + FW;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            in_valid = 1'b0, in_ready, in_sub = 1'b0;
    logic [FW-1:0]   in_a = '0, in_b = '0;
    logic [TAGW-1:0] in_tag = '0;
    logic            out_valid, out_ready = 1'b1;
    logic [FW-1:0]   out_y;
    logic [TAGW-1:0] out_tag;
    logic [2:0]      out_flags;

    fpu_addsub_pipe #(.EW(EW), .MW(MW), .TAGW(TAGW)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_sub(in_sub),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_tag(out_tag), .out_flags(out_flags)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0, n_fail = 0, n_in = 0, n_out = 0;
    int or_mode = 0;      // 0: out_ready=1, 1: random, 2: out_ready=0
    bit lat_en = 1'b0;
    logic [W-1:0] exp_q[$];
    int           acc_q[$];
    logic [W-1:0] drv_exp = '0;

    logic [FW-1:0] va [NV];
    logic [FW-1:0] vb [NV];
    logic          vs [NV];
    logic [FW-1:0] vy [NV];
    logic [2:0]    vf [NV];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%h exp=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic set_vec(input int i, input logic [FW-1:0] a, input logic [FW-1:0] b,
                           input logic s, input logic [FW-1:0] y, input logic [2:0] f);
        va[i] = a; vb[i] = b; vs[i] = s; vy[i] = y; vf[i] = f;
    endtask

    task automatic load_vectors();
        set_vec(0,  32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000);
        set_vec(1,  32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000);
        set_vec(2,  32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000);
        set_vec(3,  32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 3'b000);
        set_vec(4,  32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001);
        set_vec(5,  32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001);
        set_vec(6,  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011);
        set_vec(7,  32'h7F800000, 32'h7F800000, 1'b1, 32'hFFC00000, 3'b100);
        set_vec(8,  32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00001, 3'b000);
        set_vec(9,  32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 3'b000);
        set_vec(10, 32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 3'b000);
        set_vec(11, 32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 3'b000);
        set_vec(12, 32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 3'b000);
        set_vec(13, 32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, 3'b000);
        set_vec(14, 32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000);
        set_vec(15, 32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 3'b000);
        set_vec(16, 32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000, 3'b000);
        set_vec(17, 32'h3F800000, 32'h7F800005, 1'b0, 32'h7FC00005, 3'b000);
        set_vec(18, 32'h7FC00001, 32'h7F800002, 1'b0, 32'h7FC00001, 3'b000);
        set_vec(19, 32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 32'hFF800000, 3'b011);
        set_vec(20, 32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 3'b001);
        set_vec(21, 32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 3'b001);
        set_vec(22, 32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000, 3'b001);
        set_vec(23, 32'h3F800000, 32'h33000000, 1'b1, 32'h3F800000, 3'b001);
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input int idx, input logic [TAGW-1:0] tag);
        bit got;
        got      = 1'b0;
        in_valid = 1'b1;
        in_a     = va[idx];
        in_b     = vb[idx];
        in_sub   = vs[idx];
        in_tag   = tag;
        drv_exp  = {tag, vf[idx], vy[idx]};
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
        end
        check_val("accept", 64'(got), 64'(1));
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_sub   = 1'b0;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 200 && exp_q.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        check_val("drain", 64'(exp_q.size()), 64'(0));
    endtask

    // out_ready driver, updated just after each edge (after the main driver).
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (or_mode)
                1:       out_ready = 1'($urandom_range(0, 1));
                2:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // ---------------- scoreboard / monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                n_in = n_in - exp_q.size();
                exp_q.delete();
                acc_q.delete();
            end else begin
                check_val("in_ready", 64'(in_ready), 64'(!(exp_q.size() == 2 && !out_ready)));
                if (out_valid) begin
                    check_val("out_pending", 64'(exp_q.size() != 0), 64'(1));
                    if (exp_q.size() != 0) begin
                        check_val("result", 64'({out_tag, out_flags, out_y}), 64'(exp_q[0]));
                        if (out_ready) begin
                            if (lat_en) check_val("latency", 64'(cyc - acc_q[0]), 64'(2));
                            void'(exp_q.pop_front());
                            void'(acc_q.pop_front());
                            n_out++;
                        end
                    end
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back(drv_exp);
                    acc_q.push_back(cyc);
                    n_in++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int t0;
        load_vectors();
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        check_val("rst_out_valid", 64'(out_valid), 64'(0));
        check_val("rst_in_ready", 64'(in_ready), 64'(1));
        check_val("rst_out_y", 64'(out_y), 64'(0));
        check_val("rst_out_tag", 64'(out_tag), 64'(0));
        check_val("rst_out_flags", 64'(out_flags), 64'(0));
        @(posedge clk);
        #1;

        // Directed vectors back to back, consumer always ready: 2-cycle latency, 1/cycle.
        lat_en = 1'b1;
        t0 = cyc;
        for (int i = 0; i < NV; i++) send(i, TAGW'(i));
        check_val("throughput", 64'(cyc - t0), 64'(NV));
        idle();
        wait_drain();

        // Stress: bursts of 8 with random consumer stalls.
        lat_en  = 1'b0;
        or_mode = 1;
        for (int r = 0; r < 4; r++) begin
            for (int t = 0; t < 8; t++) send(int'($urandom_range(0, NV - 1)), TAGW'(t));
        end
        idle();
        wait_drain();

        // Reset with two operations in flight, then a fresh operation.
        or_mode = 2;
        @(posedge clk);
        #1;
        send(4, 5'h11);
        send(6, 5'h12);
        rstn = 1'b0;
        idle();
        @(posedge clk);
        #1;
        rstn    = 1'b1;
        or_mode = 0;
        @(negedge clk);
        check_val("midrst_out_valid", 64'(out_valid), 64'(0));
        check_val("midrst_in_ready", 64'(in_ready), 64'(1));
        check_val("midrst_out_y", 64'(out_y), 64'(0));
        @(posedge clk);
        #1;
        lat_en = 1'b1;
        send(0, 5'h13);
        idle();
        wait_drain();

        check_val("in_out_count", 64'(n_out), 64'(n_in));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
